// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with a bounded hold window for the current owner.
// Grants are combinational; read data returns one cycle after a granted read.
module mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [15:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [15:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  owner_t     owner;
  owner_t     owner_nx;
  logic       last;
  logic       last_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] cnt_inc;
  logic       rv0;
  logic       rv1;
  logic       g0;
  logic       g1;
  logic       hold_done;

  assign hold_done = (cnt >= HOLD);
  assign cnt_inc   = (cnt == 4'hf) ? cnt : cnt + 4'd1;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      unique case (owner)
        IDLE: begin
          if (r0_req && r1_req) begin
            g0 = last;
            g1 = !last;
          end else begin
            g0 = r0_req;
            g1 = r1_req;
          end
        end
        OWN0: begin
          if (r0_req) begin
            g1 = r1_req && hold_done;
            g0 = !g1;
          end else begin
            g1 = r1_req;
          end
        end
        OWN1: begin
          if (r1_req) begin
            g0 = r0_req && hold_done;
            g1 = !g0;
          end else begin
            g0 = r0_req;
          end
        end
        default: begin
          g0 = 1'b0;
          g1 = 1'b0;
        end
      endcase
    end
  end

  // A repeat grant extends the run; any change of owner restarts it at 1.
  always_comb begin
    owner_nx = IDLE;
    last_nx  = last;
    cnt_nx   = 4'd0;
    if (g0) begin
      owner_nx = OWN0;
      last_nx  = 1'b0;
      cnt_nx   = (owner == OWN0) ? cnt_inc : 4'd1;
    end else if (g1) begin
      owner_nx = OWN1;
      last_nx  = 1'b1;
      cnt_nx   = (owner == OWN1) ? cnt_inc : 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= IDLE;
      last  <= 1'b1;
      cnt   <= 4'd0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      rv0   <= g0 & ~r0_we;
      rv1   <= g1 & ~r1_we;
    end
  end

  // Masking with reset drops a return that was in flight when reset arrived.
  assign r0_gnt    = g0;
  assign r1_gnt    = g1;
  assign r0_rvalid = rv0 & ~reset;
  assign r1_rvalid = rv1 & ~reset;
  assign rdata     = mem_rdata;
  assign mem_addr  = g1 ? r1_addr : r0_addr;
  assign mem_wdata = g1 ? r1_wdata : r0_wdata;
  assign mem_we    = (g0 & r0_we) | (g1 & r1_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter.
// A queue-based model decides each cycle's winner; a monitor checks the DUT.
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0;
  logic          r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [15:0]   r0_wdata = '0;
  logic          r1_req = 1'b0;
  logic          r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [15:0]   r1_wdata = '0;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [15:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          g0;
    bit          g1;
    bit          we;
    logic [AW-1:0] addr;
    logic [15:0] wdata;
    bit          rv0;
    bit          rv1;
    logic [15:0] rdata;
  } item_t;

  item_t q[$];
  item_t mit;
  int n_cmp = 0;
  int n_bad = 0;

  // Unwritten locations read back a known address-dependent pattern.
  function automatic logic [15:0] dflt(input logic [5:0] a);
    return 16'h1234 + (16'(a) - 16'h0010) * 16'h0101;
  endfunction

  // Memory environment: one-cycle read latency, low 6 address bits used.
  bit [15:0] emem[64];
  bit [63:0] ewm;
  always @(posedge clk) begin
    mem_rdata <= ewm[mem_addr[5:0]] ? emem[mem_addr[5:0]]
                                    : dflt(mem_addr[5:0]);
    if (mem_we) begin
      emem[mem_addr[5:0]] <= mem_wdata;
      ewm[mem_addr[5:0]]  <= 1'b1;
    end
  end

  // Reference model state.
  bit [15:0]   mmem[64];
  bit [63:0]   mwm;
  int          m_owner = -1;
  int          m_last = 1;
  int          m_run = 0;
  bit          pv = 1'b0;
  int          pwho = 0;
  logic [15:0] pdata = '0;

  // Pending requester transactions.
  bit            p_v[2];
  bit            p_we[2];
  logic [AW-1:0] p_addr[2];
  logic [15:0]   p_wd[2];
  int            rate[2];

  function automatic int pick(input bit a, input bit b);
    if (!a && !b) return -1;
    if (a && !b) return 0;
    if (b && !a) return 1;
    if (m_owner < 0) return 1 - m_last;
    if (m_run < MH) return m_owner;
    return 1 - m_owner;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst);
    item_t it;
    int w;
    int idx;
    logic [5:0] a;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!p_v[i] && $urandom_range(99) < rate[i]) begin
        p_v[i]    = 1'b1;
        p_we[i]   = 1'($urandom_range(1));
        p_addr[i] = AW'($urandom) & AW'(16'h403F);
        p_wd[i]   = 16'($urandom);
      end
    end
    reset    = rst;
    r0_req   = p_v[0];
    r0_we    = p_we[0];
    r0_addr  = p_addr[0];
    r0_wdata = p_wd[0];
    r1_req   = p_v[1];
    r1_we    = p_we[1];
    r1_addr  = p_addr[1];
    r1_wdata = p_wd[1];
    w   = rst ? -1 : pick(p_v[0], p_v[1]);
    idx = (w < 0) ? 0 : w;
    it.g0    = (w == 0);
    it.g1    = (w == 1);
    it.we    = (w >= 0) && p_we[idx];
    it.addr  = p_addr[idx];
    it.wdata = p_wd[idx];
    it.rv0   = !rst && pv && (pwho == 0);
    it.rv1   = !rst && pv && (pwho == 1);
    it.rdata = pdata;
    q.push_back(it);
    pv = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_last  = 1;
      m_run   = 0;
    end else if (w < 0) begin
      m_owner = -1;
      m_run   = 0;
    end else begin
      m_run   = (w == m_owner) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
      m_owner = w;
      m_last  = w;
      a = p_addr[w][5:0];
      if (p_we[w]) begin
        mmem[a] = p_wd[w];
        mwm[a]  = 1'b1;
      end else begin
        pv    = 1'b1;
        pwho  = w;
        pdata = mwm[a] ? mmem[a] : dflt(a);
      end
      p_v[w] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mit = q.pop_front();
        chk("gnt", int'({r0_gnt, r1_gnt}), int'({mit.g0, mit.g1}));
        chk("mem_we", int'(mem_we), int'(mit.we));
        chk("rvalid", int'({r0_rvalid, r1_rvalid}), int'({mit.rv0, mit.rv1}));
        if (mit.g0 || mit.g1)
          chk("mem_addr", int'(mem_addr), int'(mit.addr));
        if (mit.we)
          chk("mem_wdata", int'(mem_wdata), int'(mit.wdata));
        if (mit.rv0 || mit.rv1)
          chk("rdata", int'(rdata), int'(mit.rdata));
      end
    end
  end

  initial begin
    rate[0] = 0;
    rate[1] = 0;
    repeat (3) cycle(1'b1);
    // r0 reads 0x0010, expecting the preset 0x1234
    p_v[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 15'h0010; p_wd[0] = 16'h0;
    cycle(1'b0);
    repeat (2) cycle(1'b0);
    // r1 writes 0xBEEF to 0x4000
    p_v[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 15'h4000; p_wd[1] = 16'hBEEF;
    cycle(1'b0);
    cycle(1'b0);
    // continuous contention
    rate[0] = 100;
    rate[1] = 100;
    repeat (24) cycle(1'b0);
    rate[0] = 0;
    rate[1] = 0;
    repeat (4) cycle(1'b0);
    rate[0] = 100;
    rate[1] = 100;
    repeat (6) cycle(1'b0);
    rate[0] = 0;
    rate[1] = 0;
    repeat (4) cycle(1'b0);
    // r1 read immediately followed by reset
    p_v[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 15'h0023;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    repeat (2) cycle(1'b0);
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        rate[0] = $urandom_range(100);
        rate[1] = $urandom_range(100);
      end
      cycle($urandom_range(199) == 0);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 15, width of all address ports.
REQ-002 Parameter: MAX_HOLD, default 4, range 1..15, max consecutive grants to one owner while the other requester is waiting.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 r0_req  input  1  requester 0 (CPU) access request.
REQ-006 r0_we  input  1  requester 0: 1 = write, 0 = read.
REQ-007 r0_addr  input  ADDR_W  requester 0 address.
REQ-008 r0_wdata  input  16  requester 0 write data.
REQ-009 r0_gnt  output  1  requester 0 access issued this cycle.
REQ-010 r0_rvalid  output  1  requester 0 read data valid on rdata.
REQ-011 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid  same directions and widths as the r0 ports; requester 1 (screen/DMA).
REQ-012 rdata  output  16  read return data, shared by both requesters.
REQ-013 mem_addr  output  ADDR_W  memory address, from the granted requester.
REQ-014 mem_wdata  output  16  memory write data, from the granted requester.
REQ-015 mem_we  output  1  memory write strobe; equals the granted requester's we, 0 when nothing is granted.
REQ-016 mem_rdata  input  16  memory read data, valid one cycle after the read address is presented.

Function
REQ-017 Registered state: owner (IDLE, OWN0, OWN1) = who was granted last cycle; last (0/1) = last requester served; cnt (4 bits) = consecutive grants to owner; rv0, rv1 = read-return pipeline bits.
REQ-018 Grant is combinational from registered state and current req inputs; at most one of r0_gnt/r1_gnt is high; a grant is high only if its req is high.
REQ-019 Owner IDLE: only one req -> grant it; both -> grant the requester not equal to last.
REQ-020 Owner OWNx, req_x=1, other req=0 -> grant x.
REQ-021 Owner OWNx, req_x=1, other req=1, cnt < MAX_HOLD -> grant x; cnt == MAX_HOLD -> grant the other.
REQ-022 Owner OWNx, req_x=0 -> grant the other if it requests, else no grant.
REQ-023 Next owner = granted requester, or IDLE when none is granted; last updates only on a grant.
REQ-024 cnt: 1 on a grant to a new owner or from IDLE, +1 on a repeat grant (saturating at 15), 0 when none is granted.
REQ-025 mem_addr/mem_wdata select r1 fields when r1_gnt=1, else r0 fields (a 16-bit 2:1 select); mem_we = (r0_gnt & r0_we) | (r1_gnt & r1_we).
REQ-026 A granted read in cycle N -> rx_rvalid=1 in cycle N+1 only, rdata = mem_rdata in N+1.
REQ-027 A granted write produces no rvalid; back-to-back reads yield back-to-back rvalid pulses in grant order.
REQ-028 Requesters hold req, we, addr and wdata stable until their gnt is seen high; each gnt cycle is exactly one access.
REQ-029 rdata is don't-care when both rvalid outputs are 0; r0_rvalid and r1_rvalid are never high together.

Reset
REQ-030 While reset=1: r0_gnt=r1_gnt=0, mem_we=0, r0_rvalid=r1_rvalid=0, requests ignored.
REQ-031 At reset: owner=IDLE, cnt=0, last=1 (the first contested grant goes to r0), rv0=rv1=0.
REQ-032 A read granted in the cycle before reset asserts produces no rvalid after reset; the first grant is possible in the cycle reset deasserts.

Verification
REQ-033 Reset, then r0 reads addr 0x0010 with mem returning 0x1234 -> r0_gnt in cycle 0, r0_rvalid=1 and rdata=0x1234 in cycle 1, mem_we=0 throughout.
REQ-034 Both req high continuously after reset, MAX_HOLD=4 -> grants r0,r0,r0,r0,r1,r1,r1,r1,r0..., with no gap cycles.
REQ-035 r1 writes 0xBEEF to 0x4000 while r0 idle -> mem_we=1, mem_addr=0x4000, mem_wdata=0xBEEF for one cycle; no rvalid.
REQ-036 r0 owner drops req with r1 waiting (cnt=2) -> r1_gnt in the same cycle, cnt=1 on the next edge.
REQ-037 Reset asserted in the cycle after an r1 read grant -> r1_rvalid stays 0; all outputs at reset values while reset=1.
REQ-038 Both idle for 3 cycles, then both request -> grant goes to the requester opposite last.
